// File: rtl/id_issue_scoreboard.sv
// Decode-stage issue scoreboard: per-register pending-write counters, RAW/WAW stall, post-flush bubbles.
// Optional SCOREBOARD_BYPASS_EN: a same-cycle WB release clears a last-pending source hazard.
`timescale 1ns/1ps
module id_issue_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_regwrite,
    input  logic [4:0]  id_writereg,
    input  logic        wb_writeen,
    input  logic [4:0]  wb_writereg,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_writereg,
    output logic        issue,
    output logic        stall,
    output logic        bubble,
    output logic [31:0] stall_count,
    output logic        sb_err
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [2:0]         fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [31:0]        stall_count_q, stall_count_d;
    logic               sb_err_q, sb_err_d;

    logic rs_busy, rt_busy, wr_full, hazard;

`ifdef SCOREBOARD_BYPASS_EN
    // Regfile is write-first, so the final outstanding write retiring now satisfies the read.
    assign rs_busy = (cnt_q[id_rs] != '0) &
                     ~((cnt_q[id_rs] == ONE) & wb_writeen & (wb_writereg == id_rs));
    assign rt_busy = (cnt_q[id_rt] != '0) &
                     ~((cnt_q[id_rt] == ONE) & wb_writeen & (wb_writereg == id_rt));
`else
    assign rs_busy = (cnt_q[id_rs] != '0);
    assign rt_busy = (cnt_q[id_rt] != '0);
`endif
    assign wr_full = (cnt_q[id_writereg] == MAX);
    assign hazard  = id_valid & ((id_use_rs & rs_busy) | (id_use_rt & rt_busy) |
                                 (id_regwrite & wr_full));

    assign issue  = ~reset & (state_q != FLUSH) & id_valid & ~hazard & ~flush;
    assign stall  = ~reset & (state_q != FLUSH) & id_valid & ~issue & ~flush;
    assign bubble = ~reset & ~issue;

    assign stall_count = stall_count_q;
    assign sb_err      = sb_err_q;

    always_comb begin
        int v;
        v        = 0;
        sb_err_d = sb_err_q;
        for (int r = 0; r < 32; r++) begin
            v = int'(cnt_q[r]);
            if (issue & id_regwrite & (id_writereg == 5'(r)))                 v = v + 1;
            if (wb_writeen & (wb_writereg == 5'(r)))                          v = v - 1;
            if (flush & ex_valid & ex_regwrite & (ex_writereg == 5'(r)))      v = v - 1;
            if (v < 0) begin
                sb_err_d = 1'b1;
                v        = 0;
            end else if (v > int'(MAX)) begin
                sb_err_d = 1'b1;
                v        = int'(MAX);
            end
            cnt_d[r] = (r == 0) ? '0 : v[CNT_W-1:0];
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 32'hFFFF_FFFF)
            stall_count_d = stall_count_q + 32'd1;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (flush) begin
            state_d = FLUSH;
            fcnt_d  = 3'(FLUSH_CYCLES);
        end else begin
            case (state_q)
                RUN:     if (hazard) state_d = STALL;
                STALL:   if (!hazard) state_d = RUN;
                FLUSH: begin
                    if (fcnt_q <= 3'd1) begin
                        state_d = RUN;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d  = fcnt_q - 3'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            fcnt_q        <= 3'd0;
            stall_count_q <= 32'd0;
            sb_err_q      <= 1'b0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            stall_count_q <= stall_count_d;
            sb_err_q      <= sb_err_d;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
        end
    end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed bench for id_issue_scoreboard (default build, CNT_W=2, FLUSH_CYCLES=1).
`timescale 1ns/1ps
module tb_id_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs, id_use_rt, id_regwrite;
    logic [4:0]  id_rs, id_rt, id_writereg;
    logic        wb_writeen;
    logic [4:0]  wb_writereg;
    logic        flush, ex_valid, ex_regwrite;
    logic [4:0]  ex_writereg;
    logic        issue, stall, bubble, sb_err;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    id_issue_scoreboard #(.CNT_W(2), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_regwrite(id_regwrite), .id_writereg(id_writereg),
        .wb_writeen(wb_writeen), .wb_writereg(wb_writereg),
        .flush(flush), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_writereg(ex_writereg),
        .issue(issue), .stall(stall), .bubble(bubble),
        .stall_count(stall_count), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drv_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt,
                          input logic rw, input logic [4:0] wr);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_regwrite = rw; id_writereg = wr;
    endtask

    task automatic drv_wb(input logic en, input logic [4:0] r);
        wb_writeen = en; wb_writereg = r;
    endtask

    // Next cycle's drive point; comb outputs are then sampled 1ns later.
    task automatic cyc;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drv_id(0, 0, 0, 0, 0, 0, 0);
        drv_wb(0, 0);
        flush = 0; ex_valid = 0; ex_regwrite = 0; ex_writereg = 0;
        #2;
        chk("rst_issue", 32'(issue), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bubble", 32'(bubble), 0);
        chk("rst_scnt", stall_count, 0);
        chk("rst_err", 32'(sb_err), 0);

        // RAW on r8 through WB.
        cyc; reset = 1'b0; drv_id(1, 8, 1, 9, 1, 1, 8); #1;
        chk("t1_issue", 32'(issue), 1);
        chk("t1_stall", 32'(stall), 0);
        chk("t1_scnt", stall_count, 0);
        cyc; drv_id(1, 8, 1, 0, 0, 0, 0); #1;
        chk("t2_issue", 32'(issue), 0);
        chk("t2_stall", 32'(stall), 1);
        chk("t2_bubble", 32'(bubble), 1);
        cyc; drv_wb(1, 8); #1;
        chk("t3_stall_wb", 32'(stall), 1);
        chk("t3_scnt", stall_count, 1);
        cyc; drv_wb(0, 0); #1;
        chk("t4_issue", 32'(issue), 1);
        chk("t4_scnt", stall_count, 2);
        cyc; drv_id(0, 0, 0, 0, 0, 0, 0); #1;
        chk("t5_bubble", 32'(bubble), 1);
        chk("t5_stall", 32'(stall), 0);

        // WAW saturation on r5.
        for (int i = 0; i < 3; i++) begin
            cyc; drv_id(1, 0, 0, 0, 0, 1, 5); #1;
            chk("r5_write_issue", 32'(issue), 1);
        end
        cyc; #1;
        chk("r5_full_stall", 32'(stall), 1);
        chk("r5_cnt_max", 32'(dut.cnt_q[5]), 3);
        cyc; drv_wb(1, 5); #1;
        chk("r5_wb_stall", 32'(stall), 1);
        cyc; drv_wb(0, 0); #1;
        chk("r5_after_wb_issue", 32'(issue), 1);
        chk("r5_scnt", stall_count, 4);

        // Issue and WB to the same register in one cycle.
        cyc; drv_id(1, 0, 0, 0, 0, 1, 7); #1;
        chk("r7_issue_a", 32'(issue), 1);
        cyc; drv_wb(1, 7); #1;
        chk("r7_issue_b", 32'(issue), 1);
        cyc; drv_wb(0, 0); drv_id(0, 0, 0, 0, 0, 0, 0); #1;
        chk("r7_cnt_net", 32'(dut.cnt_q[7]), 1);
        chk("r7_err", 32'(sb_err), 0);

        // Flush while stalled on r3, EX writer of r3 killed.
        cyc; drv_id(1, 0, 0, 0, 0, 1, 3); #1;
        chk("r3_issue", 32'(issue), 1);
        cyc; drv_id(1, 3, 1, 0, 0, 1, 10); #1;
        chk("r3_stall", 32'(stall), 1);
        cyc; flush = 1; ex_valid = 1; ex_regwrite = 1; ex_writereg = 3; #1;
        chk("fl_issue", 32'(issue), 0);
        chk("fl_stall", 32'(stall), 0);
        chk("fl_bubble", 32'(bubble), 1);
        cyc; flush = 0; ex_valid = 0; ex_regwrite = 0; ex_writereg = 0; #1;
        chk("fl_state_issue", 32'(issue), 0);
        chk("fl_state_stall", 32'(stall), 0);
        chk("fl_cnt_r3", 32'(dut.cnt_q[3]), 0);
        chk("fl_cnt_r10", 32'(dut.cnt_q[10]), 0);
        cyc; #1;
        chk("fl_resume_issue", 32'(issue), 1);
        chk("fl_scnt", stall_count, 5);

        // Spurious WB to an idle register.
        cyc; drv_id(0, 0, 0, 0, 0, 0, 0); drv_wb(1, 12); #1;
        chk("uf_err_before", 32'(sb_err), 0);
        cyc; drv_wb(0, 0); #1;
        chk("uf_err_set", 32'(sb_err), 1);
        chk("uf_cnt_r12", 32'(dut.cnt_q[12]), 0);
        cyc; drv_wb(1, 0); #1;
        cyc; drv_wb(0, 0); #1;
        chk("r0_cnt", 32'(dut.cnt_q[0]), 0);
        chk("err_sticky", 32'(sb_err), 1);

        // Async reset in the middle of a stall with two writes pending on r4.
        cyc; drv_id(1, 0, 0, 0, 0, 1, 4); #1;
        cyc; #1;
        cyc; drv_id(1, 4, 1, 4, 1, 0, 0); #1;
        chk("r4_stall", 32'(stall), 1);
        chk("r4_cnt", 32'(dut.cnt_q[4]), 2);
        #2 reset = 1'b1; #1;
        chk("ar_issue", 32'(issue), 0);
        chk("ar_stall", 32'(stall), 0);
        chk("ar_bubble", 32'(bubble), 0);
        chk("ar_scnt", stall_count, 0);
        chk("ar_err", 32'(sb_err), 0);
        chk("ar_cnt_r4", 32'(dut.cnt_q[4]), 0);
        chk("ar_cnt_r5", 32'(dut.cnt_q[5]), 0);
        cyc; reset = 1'b0; #1;
        chk("ar_release_issue", 32'(issue), 1);
        chk("ar_release_stall", 32'(stall), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
